nd_2to1: RTL and testbench
==========================

Name: nd_2to1

Overview:
- Merge node of the messaging-cell network; the converging counterpart of the 1-to-2 splitting node.
- Accepts messages on two receive channels (rcv0, rcv1) and forwards each one, unchanged, on a single send channel (snd0).
- All channels use the standard `NS_` link (addr, dat, req, ack) with a 4-phase level handshake.
- Fairness between the two inputs is round-robin. A one-message buffer decouples the receive side from the send side.

Parameters:
- ASZ, `NS_ADDRESS_SIZE, address field width.
- DSZ, `NS_DATA_SIZE, data field width.

Ports:
- i_clk  in  1  node clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_rcv0_addr  in  ASZ  input channel 0 address.
- i_rcv0_dat  in  DSZ  input channel 0 data.
- i_rcv0_req  in  1  input channel 0 request.
- o_rcv0_ack  out  1  input channel 0 acknowledge.
- i_rcv1_addr  in  ASZ  input channel 1 address.
- i_rcv1_dat  in  DSZ  input channel 1 data.
- i_rcv1_req  in  1  input channel 1 request.
- o_rcv1_ack  out  1  input channel 1 acknowledge.
- o_snd0_addr  out  ASZ  output channel address.
- o_snd0_dat  out  DSZ  output channel data.
- o_snd0_req  out  1  output channel request.
- i_snd0_ack  in  1  output channel acknowledge.
- o_busy  out  1  high whenever the FSM is not in ST_IDLE.
- o_last_src  out  1  index of the most recently granted input.

Behaviour:
- Reset (async, reset=0):
  - State ST_IDLE.
  - All acks and o_snd0_req = 0.
  - Buffer, o_snd0_addr, o_snd0_dat = 0.
  - o_last_src = 1, so rcv0 wins the first tie.
  - o_busy = 0.
- Handshake, per channel:
  - Sender raises req with addr/dat stable.
  - Receiver latches and raises ack.
  - Sender drops req; receiver drops ack.
  - Data must be stable while req = 1.
- FSM, one transition per i_clk edge:
  - ST_IDLE:
    - Only rcv0 req = 1: grant 0. Only rcv1 req = 1: grant 1.
    - Both req = 1: grant = ~o_last_src.
    - On grant: latch the winner's addr/dat into the buffer, set o_last_src = grant, raise o_rcvN_ack, go to ST_RACK.
    - Neither req: stay.
  - ST_RACK: when the granted req = 0, drop ack, drive the buffer onto snd0, raise o_snd0_req, go to ST_SREQ.
  - ST_SREQ: when i_snd0_ack = 1, drop o_snd0_req, go to ST_SACK.
  - ST_SACK: when i_snd0_ack = 0, go to ST_IDLE.
- Latency:
  - Ack on input: 1 clk after req is sampled high.
  - Output req: 1 clk after the granted input req falls.
  - Minimum of 4 clks per message with an immediately responding peer.
- Boundaries:
  - A non-granted req held high stays un-acked until its grant; its data is never sampled early.
  - A req rising in the same cycle as an ST_SACK→ST_IDLE transition is arbitrated on the next cycle.
  - o_snd0_addr/dat hold the last value after completion and change only at the next latch.
  - Reset mid-transfer aborts: acks and req drop immediately and the buffer is discarded. Peers must be reset together.
  - The block never modifies addr or dat.

Optional Feature:
- Macro `NS_ND_2TO1_FIXED_PRIO_EN`.
- When defined:
  - rcv0 always wins when both requests are high.
  - o_last_src is still updated for status.
  - rcv1 can starve.
- When undefined: round-robin arbitration as described above.

Decomposition:
- The shared hglobal package holds `NS_ADDRESS_SIZE`, `NS_DATA_SIZE`, `NS_ON`/`NS_OFF`, the link declare/instance macros, and new state-encoding defines (`NS_2TO1_ST_IDLE` … `NS_2TO1_ST_SACK`, 2 bits).
- Sub-module: nd_rr_arb2, a 2-way arbiter.
  - Inputs: i_req0, i_req1, i_last, i_en.
  - Outputs: o_gnt_vld, o_gnt_idx.
  - Holds the round-robin vs fixed-priority logic under the macro.

Test Plan:
1. Single message: rcv0 sends addr=2, dat=5 → o_rcv0_ack rises 1 clk later; snd0 later carries addr=2, dat=5 with req; full 4-phase cycle completes; o_last_src = 0.
2. Simultaneous requests: rcv0 (dat=1) and rcv1 (dat=6) raised together after reset → output order dat=1 then dat=6. Repeating with both held high continuously → strict alternation 0,1,0,1.
3. Output backpressure: i_snd0_ack delayed 20 clks → o_snd0_req and data held stable for all 20 clks; neither rcv ack rises meanwhile; o_busy = 1 throughout.
4. Reset mid-operation: reset=0 asserted in ST_SREQ → o_snd0_req, o_rcv*_ack and o_busy go 0 asynchronously. After release, a new rcv1 message (dat=3) is delivered correctly.
5. Fixed priority with the macro defined: both inputs continuously requesting for 4 messages → all 4 output messages from rcv0; rcv1 stays un-acked.
6. Stability: a non-granted rcv1 changes dat from 4 to 7 while waiting → output carries 7 (the value at grant time), never 4.

Source files
------------

// File: rtl/nd_2to1_pkg.sv
// Shared sizes, link levels, FSM state codes and arbitration helper for the 2-to-1 merge node.
// Pure declarations: no latency, no backpressure.
package nd_2to1_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;

  localparam logic NS_ON  = 1'b1;
  localparam logic NS_OFF = 1'b0;

  localparam logic [1:0] NS_2TO1_ST_IDLE = 2'd0;
  localparam logic [1:0] NS_2TO1_ST_RACK = 2'd1;
  localparam logic [1:0] NS_2TO1_ST_SREQ = 2'd2;
  localparam logic [1:0] NS_2TO1_ST_SACK = 2'd3;

  // Round-robin pick: on a tie the input that did not win last time goes next.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic idx;
    if (req0 && req1) begin
      idx = ~last;
    end else if (req0) begin
      idx = 1'b0;
    end else begin
      idx = 1'b1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/nd_2to1_if.sv
// NS link bundle: addr/dat qualified by a 4-phase req/ack level handshake.
// Wires only: no latency; the slave holds the master off by withholding ack.
interface nd_2to1_if
  import nd_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE
) ();

  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (
    output addr,
    output dat,
    output req,
    input  ack
  );

  modport slave (
    input  addr,
    input  dat,
    input  req,
    output ack
  );

endinterface

// File: rtl/nd_2to1_rr_arb2.sv
// Two-way combinational arbiter; round-robin by default, fixed rcv0 priority with NS_ND_2TO1_FIXED_PRIO_EN.
// Zero latency; only grants while i_en is high.
module nd_rr_arb2
  import nd_2to1_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  input  logic i_en,
  output logic o_gnt_vld,
  output logic o_gnt_idx
);

  assign o_gnt_vld = i_en & (i_req0 | i_req1);

`ifdef NS_ND_2TO1_FIXED_PRIO_EN
  // History is still tracked by the node for status, it just does not steer the grant here.
  logic unused_last;
  assign unused_last = i_last;
  assign o_gnt_idx   = i_req0 ? 1'b0 : 1'b1;
`else
  assign o_gnt_idx = rr_pick(i_req0, i_req1, i_last);
`endif

endmodule

// File: rtl/nd_2to1.sv
// Merge node: arbitrates rcv0/rcv1 into a one-message buffer and forwards it unchanged on snd0.
// Ack 1 clk after a granted req; snd req 1 clk after that req falls; holds both inputs off until snd0 completes.
module nd_2to1
  import nd_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE
) (
  input  logic         i_clk,
  input  logic         reset,
  nd_2to1_if.slave     rcv0,
  nd_2to1_if.slave     rcv1,
  nd_2to1_if.master    snd0,
  output logic         o_busy,
  output logic         o_last_src
);

  logic [1:0]     state;
  logic [ASZ-1:0] buf_addr;
  logic [DSZ-1:0] buf_dat;
  logic [ASZ-1:0] snd_addr;
  logic [DSZ-1:0] snd_dat;
  logic           snd_req;
  logic           rcv0_ack;
  logic           rcv1_ack;
  logic           last_src;

  logic           gnt_vld;
  logic           gnt_idx;
  logic           gnt_req;
  logic [ASZ-1:0] win_addr;
  logic [DSZ-1:0] win_dat;

  nd_rr_arb2 u_arb (
    .i_req0    (rcv0.req),
    .i_req1    (rcv1.req),
    .i_last    (last_src),
    .i_en      (state == NS_2TO1_ST_IDLE),
    .o_gnt_vld (gnt_vld),
    .o_gnt_idx (gnt_idx)
  );

  assign win_addr = gnt_idx ? rcv1.addr : rcv0.addr;
  assign win_dat  = gnt_idx ? rcv1.dat  : rcv0.dat;

  // last_src doubles as the index of the channel currently being acked.
  assign gnt_req  = last_src ? rcv1.req : rcv0.req;

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state    <= NS_2TO1_ST_IDLE;
      buf_addr <= '0;
      buf_dat  <= '0;
      snd_addr <= '0;
      snd_dat  <= '0;
      snd_req  <= NS_OFF;
      rcv0_ack <= NS_OFF;
      rcv1_ack <= NS_OFF;
      last_src <= 1'b1;
    end else begin
      case (state)
        NS_2TO1_ST_IDLE: begin
          if (gnt_vld) begin
            buf_addr <= win_addr;
            buf_dat  <= win_dat;
            last_src <= gnt_idx;
            rcv0_ack <= ~gnt_idx;
            rcv1_ack <= gnt_idx;
            state    <= NS_2TO1_ST_RACK;
          end
        end
        NS_2TO1_ST_RACK: begin
          if (!gnt_req) begin
            rcv0_ack <= NS_OFF;
            rcv1_ack <= NS_OFF;
            snd_addr <= buf_addr;
            snd_dat  <= buf_dat;
            snd_req  <= NS_ON;
            state    <= NS_2TO1_ST_SREQ;
          end
        end
        NS_2TO1_ST_SREQ: begin
          if (snd0.ack) begin
            snd_req <= NS_OFF;
            state   <= NS_2TO1_ST_SACK;
          end
        end
        NS_2TO1_ST_SACK: begin
          if (!snd0.ack) begin
            state <= NS_2TO1_ST_IDLE;
          end
        end
        default: state <= NS_2TO1_ST_IDLE;
      endcase
    end
  end

  assign rcv0.ack   = rcv0_ack;
  assign rcv1.ack   = rcv1_ack;
  assign snd0.addr  = snd_addr;
  assign snd0.dat   = snd_dat;
  assign snd0.req   = snd_req;
  assign o_busy     = (state != NS_2TO1_ST_IDLE);
  assign o_last_src = last_src;

endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: randomized peers plus a message-level reference model.
`timescale 1ns/1ps
module tb_nd_2to1;
  import nd_2to1_pkg::*;

  localparam int ASZ = NS_ADDRESS_SIZE;
  localparam int DSZ = NS_DATA_SIZE;

  typedef struct {
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] dat;
    logic [DSZ-1:0] alt;
    int             mut;
    int             src;
  } msg_t;

  logic i_clk;
  logic reset;
  logic o_busy;
  logic o_last_src;

  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) rcv0_l ();
  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) rcv1_l ();
  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) snd0_l ();

  nd_2to1 #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .i_clk      (i_clk),
    .reset      (reset),
    .rcv0       (rcv0_l),
    .rcv1       (rcv1_l),
    .snd0       (snd0_l),
    .o_busy     (o_busy),
    .o_last_src (o_last_src)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Peer-side drive state.
  logic           req_d  [2];
  logic [ASZ-1:0] addr_d [2];
  logic [DSZ-1:0] dat_d  [2];
  logic           snd_ack;
  logic [1:0]     ack_w;
  int gap [2];
  int hold [2];
  int gcnt [2];
  int hcnt [2];
  int wcnt [2];
  msg_t cur [2];
  int rx_delay;
  int rcnt;
  msg_t txq [$];

  assign rcv0_l.req  = req_d[0];
  assign rcv0_l.addr = addr_d[0];
  assign rcv0_l.dat  = dat_d[0];
  assign rcv1_l.req  = req_d[1];
  assign rcv1_l.addr = addr_d[1];
  assign rcv1_l.dat  = dat_d[1];
  assign snd0_l.ack  = snd_ack;
  assign ack_w       = {rcv1_l.ack, rcv0_l.ack};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state.
  msg_t exp_q [$];
  msg_t out_log [$];
  msg_t cur_out;
  msg_t mon_m;
  logic m_last;
  logic [1:0] p_req;
  logic [1:0] p_ack;
  logic p_sreq;
  logic [ASZ-1:0] p_addr [2];
  logic [DSZ-1:0] p_dat [2];

  function automatic logic model_pick();
`ifdef NS_ND_2TO1_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~m_last;
`endif
  endfunction

  // Compare process: every grant is checked against the arbitration rule and
  // every forwarded message against what the granted sender was presenting.
  always @(negedge i_clk) begin
    if (!reset) begin
      exp_q.delete();
      m_last = 1'b1;
      p_req  = '0;
      p_ack  = '0;
      p_sreq = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ack_w[c] && !p_ack[c]) begin
          chk("ack_had_req", {31'd0, p_req[c]}, 32'd1);
          chk("ack_while_snd_req", {31'd0, snd0_l.req}, 32'd0);
          if (p_req[0] && p_req[1])
            chk("arb_choice", c, {31'd0, model_pick()});
          chk("last_src", {31'd0, o_last_src}, c);
          mon_m.addr = p_addr[c];
          mon_m.dat  = p_dat[c];
          mon_m.alt  = '0;
          mon_m.mut  = 0;
          mon_m.src  = c;
          exp_q.push_back(mon_m);
          m_last = c[0];
        end
      end
      if (ack_w != 2'b00)
        chk("ack_onehot", {31'd0, ack_w[0] & ack_w[1]}, 32'd0);
      if (snd0_l.req && !p_sreq) begin
        chk("snd_has_msg", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          cur_out = exp_q.pop_front();
          chk("snd_addr", snd0_l.addr, cur_out.addr);
          chk("snd_dat", snd0_l.dat, cur_out.dat);
          out_log.push_back(cur_out);
        end
      end else if (snd0_l.req) begin
        chk("snd_addr_stable", snd0_l.addr, cur_out.addr);
        chk("snd_dat_stable", snd0_l.dat, cur_out.dat);
      end
      if (snd0_l.req || ack_w != 2'b00)
        chk("busy_when_active", {31'd0, o_busy}, 32'd1);
      p_req  = {req_d[1], req_d[0]};
      p_ack  = ack_w;
      p_sreq = snd0_l.req;
      for (int c = 0; c < 2; c++) begin
        p_addr[c] = addr_d[c];
        p_dat[c]  = dat_d[c];
      end
    end
  end

  // Sender and receiver peers, one step per clock just after the edge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (req_d[c]) begin
          if (ack_w[c]) begin
            if (hcnt[c] >= hold[c]) begin
              req_d[c] = 1'b0;
              hcnt[c]  = 0;
            end else begin
              hcnt[c]++;
            end
          end else begin
            wcnt[c]++;
            if (cur[c].mut > 0 && wcnt[c] == cur[c].mut)
              dat_d[c] = cur[c].alt;
          end
        end else if (!ack_w[c]) begin
          if (gcnt[c] < gap[c]) begin
            gcnt[c]++;
          end else begin
            int idx;
            idx = -1;
            for (int i = 0; i < txq.size(); i++) begin
              if (idx < 0 && txq[i].src == c) idx = i;
            end
            if (idx >= 0) begin
              cur[c] = txq[idx];
              txq.delete(idx);
              addr_d[c] = cur[c].addr;
              dat_d[c]  = cur[c].dat;
              req_d[c]  = 1'b1;
              wcnt[c]   = 0;
              gcnt[c]   = 0;
            end
          end
        end
      end
      if (snd_ack) begin
        if (!snd0_l.req) snd_ack = 1'b0;
      end else if (snd0_l.req) begin
        if (rcnt >= rx_delay) begin
          snd_ack = 1'b1;
          rcnt    = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic push(input int src, input int addr, input int dat, input int alt, input int mut);
    msg_t m;
    m.addr = addr[ASZ-1:0];
    m.dat  = dat[DSZ-1:0];
    m.alt  = alt[DSZ-1:0];
    m.mut  = mut;
    m.src  = src;
    txq.push_back(m);
  endtask

  task automatic clear_peers();
    txq.delete();
    for (int c = 0; c < 2; c++) begin
      req_d[c]  = 1'b0;
      addr_d[c] = '0;
      dat_d[c]  = '0;
      gcnt[c]   = 0;
      hcnt[c]   = 0;
      wcnt[c]   = 0;
      gap[c]    = 0;
      hold[c]   = 0;
    end
    snd_ack  = 1'b0;
    rcnt     = 0;
    rx_delay = 0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((txq.size() != 0 || req_d[0] || req_d[1] || ack_w != 2'b00 ||
            snd0_l.req || snd_ack || o_busy) && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_drain"}, {31'd0, n < 3000}, 32'd1);
    chk({name, "_model_empty"}, exp_q.size(), 32'd0);
    @(negedge i_clk);
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    #1;
    reset = 1'b0;
    clear_peers();
    @(negedge i_clk);
    #1;
    reset = 1'b1;
    out_log.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bp;
    int bad;
    int pushed;
    logic [ASZ-1:0] hold_addr;
    logic [DSZ-1:0] hold_dat;
    logic [1:0] rr_exp [8];

    reset = 1'b0;
    clear_peers();
    repeat (3) @(negedge i_clk);

    // Reset state.
    chk("rst_ack0", {31'd0, rcv0_l.ack}, 32'd0);
    chk("rst_ack1", {31'd0, rcv1_l.ack}, 32'd0);
    chk("rst_sreq", {31'd0, snd0_l.req}, 32'd0);
    chk("rst_saddr", snd0_l.addr, 32'd0);
    chk("rst_sdat", snd0_l.dat, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_last", {31'd0, o_last_src}, 32'd1);
    #1;
    reset = 1'b1;
    @(negedge i_clk);

    // Single message with cycle-exact handshake timing.
    push(0, 2, 5, 0, 0);
    n = 0;
    while (!req_d[0] && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    chk("t1_req_seen", {31'd0, req_d[0]}, 32'd1);
    chk("t1_ack_pre", {31'd0, rcv0_l.ack}, 32'd0);
    @(negedge i_clk);
    chk("t1_ack_1clk", {31'd0, rcv0_l.ack}, 32'd1);
    chk("t1_busy", {31'd0, o_busy}, 32'd1);
    chk("t1_sreq_pre", {31'd0, snd0_l.req}, 32'd0);
    @(negedge i_clk);
    chk("t1_sreq", {31'd0, snd0_l.req}, 32'd1);
    chk("t1_saddr", snd0_l.addr, 32'd2);
    chk("t1_sdat", snd0_l.dat, 32'd5);
    drain("t1");
    chk("t1_last_src", {31'd0, o_last_src}, 32'd0);
    chk("t1_idle", {31'd0, o_busy}, 32'd0);
    chk("t1_hold_addr", snd0_l.addr, 32'd2);
    chk("t1_hold_dat", snd0_l.dat, 32'd5);

    // Simultaneous requests after reset, then both held continuously.
    pulse_reset();
    push(0, 1, 1, 0, 0);
    push(1, 3, 6, 0, 0);
    drain("t2a");
    chk("t2_count", out_log.size(), 32'd2);
    if (out_log.size() == 2) begin
      chk("t2_first_dat", out_log[0].dat, 32'd1);
      chk("t2_second_dat", out_log[1].dat, 32'd6);
    end
    out_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 8 + i, i, 0, 0);
      push(1, 16 + i, 8 + i, 0, 0);
    end
`ifdef NS_ND_2TO1_FIXED_PRIO_EN
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
`else
    rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
    drain("t2b");
    chk("t2_cont_count", out_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < out_log.size())
        chk("t2_order_src", out_log[i].src, {30'd0, rr_exp[i]});
    end

    // Output backpressure: downstream ack held off for 20 clks.
    rx_delay = 20;
    push(0, 5, 10, 0, 0);
    push(1, 6, 11, 0, 0);
    n = 0;
    while (!snd0_l.req && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    hold_addr = snd0_l.addr;
    hold_dat  = snd0_l.dat;
    chk("t3_first_addr", hold_addr, 32'd5);
    bp = 0;
    bad = 0;
    while (snd0_l.req && bp < 200) begin
      if (ack_w != 2'b00 || !o_busy || snd0_l.addr !== hold_addr || snd0_l.dat !== hold_dat)
        bad++;
      bp++;
      @(negedge i_clk);
    end
    chk("t3_bp_cycles", {31'd0, bp >= 20}, 32'd1);
    chk("t3_bp_bad", bad, 32'd0);
    drain("t3");

    // Reset while the output request is pending.
    rx_delay = 50;
    push(0, 1, 2, 0, 0);
    n = 0;
    while (!snd0_l.req && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("t4_in_sreq", {31'd0, snd0_l.req}, 32'd1);
    #1;
    reset = 1'b0;
    clear_peers();
    #1;
    chk("t4_sreq_async", {31'd0, snd0_l.req}, 32'd0);
    chk("t4_acks_async", {30'd0, ack_w}, 32'd0);
    chk("t4_busy_async", {31'd0, o_busy}, 32'd0);
    chk("t4_last_async", {31'd0, o_last_src}, 32'd1);
    chk("t4_saddr_async", snd0_l.addr, 32'd0);
    @(negedge i_clk);
    #1;
    reset = 1'b1;
    out_log.delete();
    push(1, 4, 3, 0, 0);
    drain("t4");
    chk("t4_count", out_log.size(), 32'd1);
    if (out_log.size() == 1) begin
      chk("t4_dat", out_log[0].dat, 32'd3);
      chk("t4_src", out_log[0].src, 32'd1);
    end

    // Waiting rcv1 changes its data before grant: the granted value is forwarded.
    rx_delay = 10;
    out_log.delete();
    push(0, 1, 9, 0, 0);
    push(1, 2, 4, 7, 3);
    drain("t6");
    chk("t6_count", out_log.size(), 32'd2);
    if (out_log.size() == 2) begin
      chk("t6_first_dat", out_log[0].dat, 32'd9);
      chk("t6_late_dat", out_log[1].dat, 32'd7);
      chk("t6_late_src", out_log[1].src, 32'd1);
    end

    // Randomized traffic rounds.
    for (int r = 0; r < 4; r++) begin
      out_log.delete();
      rx_delay = $urandom_range(0, 3);
      for (int c = 0; c < 2; c++) begin
        gap[c]  = $urandom_range(0, 3);
        hold[c] = $urandom_range(0, 2);
      end
      pushed = 0;
      for (int i = 0; i < 25; i++) begin
        int src;
        int mut;
        src = $urandom_range(0, 1);
        mut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        push(src, $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15), mut);
        pushed++;
      end
      drain("rand");
      chk("rand_count", out_log.size(), pushed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
